// File: rtl/latency_probe_arbiter.sv
// Shares one AXI-stream output between user packets and latency probes, then snoops the return path to time probes.
// Optional LATENCY_MINMAX_EN: tracks running min/max latency; otherwise lat_min/lat_max are tied to 0.
module latency_probe_arbiter #(
  parameter int          PERIOD_W = 16,
  parameter logic [31:0] MAGIC    = 32'hABCDBEEF,
  parameter int          TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [63:0]         timer,
  input  logic [31:0]         s_tdata,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [31:0]         o_tdata,
  output logic                o_tlast,
  output logic                o_tvalid,
  input  logic                o_tready,
  input  logic [31:0]         r_tdata,
  input  logic                r_tvalid,
  input  logic                r_tready,
  output logic [31:0]         lat_data,
  output logic                lat_valid,
  output logic [31:0]         lat_min,
  output logic [31:0]         lat_max,
  output logic [15:0]         probe_cnt,
  output logic [15:0]         lost_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PROBE0 = 2'd2;
  localparam logic [1:0] S_PROBE1 = 2'd3;

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]          state, nxt;
  logic [PERIOD_W-1:0] per_cnt, period_q;
  logic                pending, outstanding, armed;
  logic [31:0]         tx_ts;
  logic [TW-1:0]       tmo_cnt;
  logic [31:0]         lat_new;
  logic                per_restart, per_wrap;
  logic                p0_hs, p1_hs, r_hs, ret, tmo;
  logic                unused_timer_hi;

  assign unused_timer_hi = ^timer[63:32];

  // A changed period value restarts the count so the new interval starts cleanly
  assign per_restart = !enable || (period == '0) || (period != period_q);
  assign per_wrap    = !per_restart && (per_cnt == period - 1'b1);

  assign p0_hs   = (state == S_PROBE0) && o_tready;
  assign p1_hs   = (state == S_PROBE1) && o_tready;
  assign r_hs    = r_tvalid && r_tready;
  assign ret     = r_hs && armed && outstanding;
  assign tmo     = outstanding && !ret && (tmo_cnt == TMO_LAST);
  assign lat_new = timer[31:0] - r_tdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt  <= '0;
      period_q <= '0;
      pending  <= 1'b0;
    end else begin
      period_q <= period;
      if (per_restart || per_wrap) per_cnt <= '0;
      else                         per_cnt <= per_cnt + 1'b1;
      if (!enable)       pending <= 1'b0;
      else if (per_wrap) pending <= 1'b1;
      else if (p1_hs)    pending <= 1'b0;
    end
  end

  // Probes are only considered from IDLE, so they never split a user packet
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (pending && !outstanding) nxt = S_PROBE0;
        else if (s_tvalid)           nxt = S_DATA;
      end
      S_DATA:   if (s_tvalid && o_tready && s_tlast) nxt = S_IDLE;
      S_PROBE0: if (o_tready) nxt = S_PROBE1;
      S_PROBE1: if (o_tready) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_tdata  = '0;
    o_tlast  = 1'b0;
    o_tvalid = 1'b0;
    s_tready = 1'b0;
    case (state)
      S_DATA: begin
        o_tdata  = s_tdata;
        o_tlast  = s_tlast;
        o_tvalid = s_tvalid;
        s_tready = o_tready;
      end
      S_PROBE0: begin
        o_tdata  = MAGIC;
        o_tvalid = 1'b1;
      end
      S_PROBE1: begin
        o_tdata  = tx_ts;
        o_tlast  = 1'b1;
        o_tvalid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tx_ts     <= '0;
      probe_cnt <= '0;
    end else begin
      state <= nxt;
      if (p0_hs) tx_ts <= timer[31:0];
      if (p1_hs) probe_cnt <= probe_cnt + 1'b1;
    end
  end

  // Return snoop: MAGIC arms the matcher only while a probe is in flight; the next beat is its timestamp
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= 1'b0;
      armed       <= 1'b0;
      tmo_cnt     <= '0;
      lost_cnt    <= '0;
      lat_data    <= '0;
      lat_valid   <= 1'b0;
    end else begin
      lat_valid <= ret;
      if (ret) lat_data <= lat_new;
      if (p1_hs)            outstanding <= 1'b1;
      else if (ret || tmo)  outstanding <= 1'b0;
      tmo_cnt <= outstanding ? tmo_cnt + 1'b1 : '0;
      if (tmo)       armed <= 1'b0;
      else if (r_hs) armed <= !armed && outstanding && (r_tdata == MAGIC);
      if (tmo) lost_cnt <= lost_cnt + 1'b1;
    end
  end

`ifdef LATENCY_MINMAX_EN
  logic enable_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b0;
      lat_min  <= 32'hFFFF_FFFF;
      lat_max  <= '0;
    end else begin
      enable_q <= enable;
      if (enable_q && !enable) begin
        lat_min <= 32'hFFFF_FFFF;
        lat_max <= '0;
      end else if (ret) begin
        if (lat_new < lat_min) lat_min <= lat_new;
        if (lat_new > lat_max) lat_max <= lat_new;
      end
    end
  end
`else
  assign lat_min = '0;
  assign lat_max = '0;
`endif

endmodule

// File: tb/tb_latency_probe_arbiter.sv
// Scoreboard bench: user beats and expected latencies are queued at issue; a negedge monitor pops and compares.
module tb_latency_probe_arbiter;
  localparam int          TMO   = 4096;
  localparam int          D     = 4;
  localparam logic [31:0] MAGIC = 32'hABCDBEEF;

  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic [15:0] period = '0;
  logic [63:0] timer = '0;
  logic [31:0] s_tdata = '0, o_tdata, r_tdata, lat_data, lat_min, lat_max;
  logic        s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
  logic        o_tlast, o_tvalid, o_tready = 1'b1;
  logic        r_tvalid, r_tready = 1'b1, lat_valid;
  logic [15:0] probe_cnt, lost_cnt;

  latency_probe_arbiter #(.PERIOD_W(16), .MAGIC(MAGIC), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .period(period), .timer(timer),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .r_tdata(r_tdata), .r_tvalid(r_tvalid), .r_tready(r_tready),
    .lat_data(lat_data), .lat_valid(lat_valid), .lat_min(lat_min), .lat_max(lat_max),
    .probe_cnt(probe_cnt), .lost_cnt(lost_cnt));

  always #5 clk = ~clk;

  int          cyc = 0;
  logic [31:0] toff = '0;
  always @(posedge clk) begin
    #1;
    cyc++;
    timer = {32'h0, 32'(cyc) + toff};
  end

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // return path: either a D-cycle loopback of output handshakes, or manual beats
  logic         loop_en = 1'b1, man_v = 1'b0, rdy_rand = 1'b0;
  logic [31:0]  man_d = '0;
  logic         o_hs_c = 1'b0;
  logic [31:0]  o_d_c = '0;
  logic [D-1:0] pv = '0;
  logic [31:0]  pd [D];
  always @(posedge clk) begin
    pv    <= {pv[D-2:0], o_hs_c};
    pd[0] <= o_d_c;
    for (int i = 1; i < D; i++) pd[i] <= pd[i-1];
  end
  assign r_tvalid = loop_en ? pv[D-1] : man_v;
  assign r_tdata  = loop_en ? pd[D-1] : man_d;

  always @(posedge clk) begin
    #2;
    o_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // reference model state
  logic [32:0] uq[$];
  logic [31:0] lq[$];
  bit          in_pkt = 0, exp_ts = 0, m_out = 0, armed = 0;
  logic [31:0] ts_exp = '0, last_ts = '0, m_min = 32'hFFFF_FFFF, m_max = '0;
  int          n_probes = 0, m_lost = 0, m_L = 0, mag_cyc = 0;

  always @(negedge clk) begin
    o_hs_c = o_tvalid && o_tready;
    o_d_c  = o_tdata;
    if (reset_n) begin
      if (lat_valid) begin
        if (lq.size() == 0) chk("lat_unexpected", lat_data, 32'hx);
        else begin
          logic [31:0] e;
          e = lq.pop_front();
          chk("lat_data", lat_data, e);
`ifdef LATENCY_MINMAX_EN
          if (e < m_min) m_min = e;
          if (e > m_max) m_max = e;
`else
          m_min = '0;
          m_max = '0;
`endif
          chk("lat_min", lat_min, m_min);
          chk("lat_max", lat_max, m_max);
          chk("lost_at_lat", {16'h0, lost_cnt}, 32'(m_lost));
        end
      end
      if (o_hs_c) begin
        if (exp_ts) begin
          chk("probe_ts", o_tdata, ts_exp);
          chk("probe_tlast1", {31'h0, o_tlast}, 32'd1);
          chk("probe_cnt", {16'h0, probe_cnt}, 32'(n_probes & 16'hFFFF));
          exp_ts = 0; n_probes++; m_out = 1; m_L = cyc; last_ts = ts_exp;
        end else if (!in_pkt && o_tdata == MAGIC) begin
          chk("probe_tlast0", {31'h0, o_tlast}, 32'd0);
          chk("probe_while_outstanding", {31'h0, m_out}, 32'd0);
          chk("probe_enabled", {31'h0, enable}, 32'd1);
          exp_ts = 1; ts_exp = timer[31:0]; mag_cyc = cyc;
        end else if (uq.size() == 0) begin
          chk("beat_unexpected", o_tdata, 32'hx);
        end else begin
          logic [32:0] b;
          b = uq.pop_front();
          chk("beat_data", o_tdata, b[31:0]);
          chk("beat_last", {31'h0, o_tlast}, {31'h0, b[32]});
          in_pkt = !o_tlast;
        end
      end
      if (r_tvalid && r_tready) begin
        if (armed) begin
          armed = 0;
          if (m_out) begin lq.push_back(timer[31:0] - r_tdata); m_out = 0; end
        end else if (m_out && r_tdata == MAGIC) armed = 1;
      end
      if (m_out && cyc == m_L + TMO) begin m_lost++; m_out = 0; armed = 0; end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    bit hs;
    hs = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
    uq.push_back({last, d});
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (s_tready) begin hs = 1; break; end
    end
    tick();
    s_tvalid = 1'b0;
    if (!hs) chk("s_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_probe(input int bound);
    int n0, k;
    n0 = n_probes; k = 0;
    while (n_probes == n0 && k < bound) begin tick(); k++; end
    if (n_probes == n0) chk("wait_probe_timeout", 32'd0, 32'd1);
  endtask

  task automatic manual_return(input logic [31:0] lat, input bit wrap);
    wait_probe(9000);
    tick();
    man_v = 1'b1; man_d = MAGIC;
    if (wrap) toff = 32'd3 - 32'(cyc + 1);
    tick();
    man_d = timer[31:0] - lat;
    tick();
    man_v = 1'b0;
    chk("lat_valid_manual", {31'h0, lat_valid}, 32'd1);
    chk("lat_manual", lat_data, lat);
  endtask

  initial begin
    #(2000000 * 10);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, L, L2, prev;
    logic [31:0] d;
    period = 16'd100;
    #23;
    chk("rst_o_tvalid", {31'h0, o_tvalid}, 32'd0);
    chk("rst_s_tready", {31'h0, s_tready}, 32'd0);
    chk("rst_o_tdata", o_tdata, 32'd0);
    chk("rst_lat_valid", {31'h0, lat_valid}, 32'd0);
    chk("rst_lat_data", lat_data, 32'd0);
    chk("rst_probe_cnt", {16'h0, probe_cnt}, 32'd0);
    chk("rst_lost_cnt", {16'h0, lost_cnt}, 32'd0);
`ifdef LATENCY_MINMAX_EN
    chk("rst_lat_min", lat_min, 32'hFFFF_FFFF);
`else
    chk("rst_lat_min", lat_min, 32'd0);
`endif
    chk("rst_lat_max", lat_max, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // pass-through with probing disabled
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 8; b++) begin
        d = $urandom; if (d == MAGIC) d = ~d;
        send_beat(d, b == 7);
      end
    repeat (200) tick();
    chk("disabled_probe_cnt", {16'h0, probe_cnt}, 32'd0);
    chk("disabled_drained", 32'(uq.size()), 32'd0);

    // idle loopback: fixed period, fixed latency
    enable = 1'b1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_probe(400);
      if (k > 0) chk("probe_period", 32'(mag_cyc - prev), 32'd100);
      prev = mag_cyc;
      for (int w = 0; w < 20 && !lat_valid; w++) tick();
      chk("idle_lat", lat_data, 32'd5);
    end

    // random traffic with backpressure; probes must fall between packets
    rdy_rand = 1'b1;
    period = 16'($urandom_range(15, 60));
    for (int p = 0; p < 80; p++) begin
      int len;
      len = $urandom_range(1, 12);
      if (p == 40) period = 16'($urandom_range(15, 60));
      for (int b = 0; b < len; b++) begin
        d = $urandom; if (d == MAGIC) d = d ^ 32'h1;
        send_beat(d, b == len - 1);
      end
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) tick();
    end
    rdy_rand = 1'b0;
    period = 16'd100;
    repeat (60) tick();
    chk("random_drained", 32'(uq.size()), 32'd0);

    // return path cut: probe times out after TMO cycles
    loop_en = 1'b0;
    wait_probe(9000);
    L = m_L;
    l0 = 32'(lost_cnt);
    while (cyc < L + TMO) tick();
    chk("lost_before_tmo", {16'h0, lost_cnt}, 32'(l0));
    tick();
    chk("lost_after_tmo", {16'h0, lost_cnt}, 32'(l0 + 1));

    // next probe returns on the exact timeout cycle: return wins
    wait_probe(400);
    L2 = m_L;
    while (cyc < L2 + TMO - 1) tick();
    man_v = 1'b1; man_d = MAGIC;
    tick();
    man_d = last_ts;
    tick();
    man_v = 1'b0;
    chk("lat_valid_on_tmo", {31'h0, lat_valid}, 32'd1);
    tick();
    chk("lost_unchanged_on_tmo", {16'h0, lost_cnt}, 32'(l0 + 1));

    // timer wraps between launch and return
    manual_return(32'd5, 1'b1);

    // running extremes, cleared by dropping enable
    enable = 1'b0;
    repeat (3) tick();
    m_min = 32'hFFFF_FFFF; m_max = '0;
    enable = 1'b1;
    manual_return(32'd7, 1'b0);
    manual_return(32'd3, 1'b0);
    manual_return(32'd9, 1'b0);
    tick();
`ifdef LATENCY_MINMAX_EN
    chk("minmax_min", lat_min, 32'd3);
    chk("minmax_max", lat_max, 32'd9);
`else
    chk("minmax_min_tied", lat_min, 32'd0);
    chk("minmax_max_tied", lat_max, 32'd0);
`endif

    repeat (20) tick();
    chk("final_probe_cnt", {16'h0, probe_cnt}, 32'(n_probes & 16'hFFFF));
    chk("final_lost_cnt", {16'h0, lost_cnt}, 32'(m_lost));
    chk("final_lat_queue", 32'(lq.size()), 32'd0);
    chk("final_beat_queue", 32'(uq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
